// File: rtl/clock_period_meter.sv
// Clock period meter: recovers period and high time of a slow square wave in clk
// cycles, and locks once consecutive periods agree within TOL.
module clock_period_meter #(
  parameter int WIDTH      = 8,
  parameter int TOL        = 1,
  parameter int LOCK_COUNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             overflow
);

  localparam int               MW      = $clog2(LOCK_COUNT + 1);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_OVF = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [MW-1:0]    LOCK_V  = MW'(LOCK_COUNT);
  localparam logic [WIDTH:0]   TOL_V   = (WIDTH+1)'(TOL);

  typedef enum logic [1:0] {IDLE, MEASURE, TRACK} state_t;

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v,
                                               input logic             inc);
    if (inc && (v != CNT_MAX)) return v + WIDTH'(1);
    return v;
  endfunction

  // One extra bit keeps the signed difference exact for any pair of periods.
  function automatic logic [WIDTH:0] abs_diff(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic signed [WIDTH:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[WIDTH] ? $unsigned(-d) : $unsigned(d);
  endfunction

  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [WIDTH-1:0] period_q, period_d, high_q, high_d;
  logic [MW-1:0]    match_q, match_d;
  logic             valid_q, valid_d, locked_q, locked_d, ovf_q, ovf_d;
  state_t           state_q, state_d;
  logic             rise, in_range;
  logic [WIDTH-1:0] p_meas, h_meas;

  assign rise     = s2_q & ~s3_q;
  assign p_meas   = cnt_q + WIDTH'(1);
  assign h_meas   = hcnt_q + WIDTH'(s2_q);
  assign in_range = (abs_diff(p_meas, period_q) <= TOL_V);

  always_comb begin
    cnt_d    = rise ? '0 : sat_inc(cnt_q, 1'b1);
    hcnt_d   = rise ? '0 : sat_inc(hcnt_q, s2_q);
    state_d  = state_q;
    period_d = period_q;
    high_d   = high_q;
    match_d  = match_q;
    locked_d = locked_q;
    valid_d  = 1'b0;
    ovf_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) state_d = MEASURE;
      end
      MEASURE, TRACK: begin
        if (rise) begin
          period_d = p_meas;
          high_d   = h_meas;
          valid_d  = 1'b1;
          state_d  = TRACK;
          // The first captured period has nothing to compare against.
          if ((state_q == MEASURE) || !in_range) match_d = '0;
          else if (match_q != LOCK_V)            match_d = match_q + MW'(1);
          locked_d = (match_d == LOCK_V);
        end else if (cnt_q == CNT_OVF) begin
          ovf_d    = 1'b1;
          locked_d = 1'b0;
          match_d  = '0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      match_q  <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
      state_q  <= IDLE;
    end else begin
      s1_q     <= sig_in;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      match_q  <= match_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
    end
  end

  assign period       = period_q;
  assign high_time    = high_q;
  assign period_valid = valid_q;
  assign locked       = locked_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: directed and randomized waveforms checked cycle by
// cycle against an edge-list reference model of period, high time, lock and overflow.
module tb_clock_period_meter;

  localparam int WIDTH      = 8;
  localparam int TOL        = 1;
  localparam int LOCK_COUNT = 4;
  localparam int MAXP       = (1 << WIDTH) - 1;
  localparam int LAT        = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             sig_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             period_valid;
  logic             locked;
  logic             overflow;

  clock_period_meter #(.WIDTH(WIDTH), .TOL(TOL), .LOCK_COUNT(LOCK_COUNT)) dut (
    .clk          (clk),
    .reset        (reset),
    .sig_in       (sig_in),
    .period       (period),
    .high_time    (high_time),
    .period_valid (period_valid),
    .locked       (locked),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] per;
    logic [WIDTH-1:0] ht;
    logic             pv;
    logic             lck;
    logic             ov;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: sample index, last rise index, high samples since it,
  // previous period and the current run of consecutive in-tolerance periods.
  int m_k, m_last, m_hacc, m_pprev, m_run, m_per, m_ht;
  bit m_prev, m_started, m_have, m_lck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_k = 0; m_last = 0; m_hacc = 0; m_pprev = 0; m_run = 0; m_per = 0; m_ht = 0;
    m_prev = 1'b0; m_started = 1'b0; m_have = 1'b0; m_lck = 1'b0;
  endtask

  task automatic push_zero(input int n);
    exp_t e;
    e = '0;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic model_step(input bit v);
    exp_t e;
    bit   rise;
    int   p, d;
    e.pv = 1'b0;
    e.ov = 1'b0;
    rise = v && !m_prev;
    if (m_started && !rise && (m_k - m_last) == MAXP) begin
      e.ov = 1'b1; m_lck = 1'b0; m_started = 1'b0; m_have = 1'b0; m_run = 0;
    end else if (rise) begin
      if (m_started) begin
        p = m_k - m_last;
        m_per = p; m_ht = m_hacc; e.pv = 1'b1;
        d = p - m_pprev;
        if (d < 0) d = -d;
        if (m_have && d <= TOL) m_run++;
        else                    m_run = 0;
        m_lck = (m_run >= LOCK_COUNT);
        m_pprev = p; m_have = 1'b1;
      end
      m_started = 1'b1; m_last = m_k; m_hacc = 0;
    end
    m_hacc += int'(v);
    m_prev = v;
    m_k++;
    e.per = m_per[WIDTH-1:0];
    e.ht  = m_ht[WIDTH-1:0];
    e.lck = m_lck;
    exp_q.push_back(e);
  endtask

  task automatic compare_outputs(input exp_t e);
    chk("period", 32'(period), 32'(e.per));
    chk("high_time", 32'(high_time), 32'(e.ht));
    chk("period_valid", 32'(period_valid), 32'(e.pv));
    chk("locked", 32'(locked), 32'(e.lck));
    chk("overflow", 32'(overflow), 32'(e.ov));
    chk("valid_ovf_exclusive", 32'(period_valid & overflow), 32'd0);
  endtask

  task automatic cyc(input bit v);
    exp_t e;
    @(posedge clk);
    #1;
    sig_in = v;
    model_step(v);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("expect_queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      compare_outputs(e);
    end
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < hi; j++) cyc(1'b1);
      for (int j = 0; j < lo; j++) cyc(1'b0);
    end
  endtask

  // Asynchronous reset held across one clk edge, released on the following negedge.
  task automatic mid_reset(input bit v);
    exp_t e;
    reset = 1'b0;
    #1;
    e = '0;
    compare_outputs(e);
    exp_q.delete();
    reset_model();
    push_zero(LAT);
    @(posedge clk);
    #1;
    sig_in = v;
    model_step(v);
    @(negedge clk);
    reset = 1'b1;
    e = exp_q.pop_front();
    compare_outputs(e);
  endtask

  initial begin
    exp_t z;
    int   bhi, blo, jit;
    reset  = 1'b0;
    sig_in = 1'b0;
    reset_model();
    push_zero(LAT);
    repeat (2) @(posedge clk);
    @(negedge clk);
    z = '0;
    compare_outputs(z);
    reset = 1'b1;

    wave(1, 1, 10);                    // div2
    wave(4, 4, 8);                     // div8, lock on 5th valid
    wave(5, 5, 1);                     // one period of 10 drops lock
    wave(4, 4, 7);
    wave(5, 4, 1);                     // period 9 keeps lock
    wave(4, 4, 3);
    for (int i = 0; i < 300; i++) cyc(1'b0);   // stuck low -> overflow
    wave(4, 4, 3);
    wave(3, 5, 7);                     // duty change
    wave(1, 7, 3);
    wave(4, 4, 6);
    cyc(1'b1);
    cyc(1'b1);
    mid_reset(1'b1);
    wave(2, 4, 1);
    wave(4, 4, 8);
    for (int i = 0; i < 300; i++) cyc(1'b1);   // stuck high -> overflow
    for (int i = 0; i < 10; i++) cyc(1'b0);
    wave(4, 4, 5);
    wave(100, 155, 1);                 // longest measurable period
    wave(4, 4, 2);
    wave(100, 156, 1);                 // one cycle too long
    wave(4, 4, 6);

    for (int r = 0; r < 5; r++) begin
      bhi = $urandom_range(1, 8);
      blo = $urandom_range(1, 8);
      for (int i = 0; i < 12; i++) begin
        jit = $urandom_range(0, 5);
        wave(bhi, blo + ((jit == 0) ? 2 : (jit == 1) ? 1 : 0), 1);
      end
      if ($urandom_range(0, 2) == 0) mid_reset(1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 8; i++) cyc(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
